// File: rtl/fifo_access_scheduler.sv
// Shares one edge-strobed BRAM sample FIFO between NUM_WR round-robin producers
// and a single playback consumer. Every access is an IDLE decision cycle plus one strobe cycle.
module fifo_access_scheduler #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 512,
  parameter int NUM_WR   = 4,
  parameter int RD_GUARD = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_WR-1:0]          wr_req,
  input  logic [NUM_WR*WIDTH-1:0]    wr_data,
  output logic [NUM_WR-1:0]          wr_ack,
  input  logic                       rd_req,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       fifo_wr,
  output logic [WIDTH-1:0]           fifo_din,
  output logic                       fifo_rd,
  input  logic [WIDTH-1:0]           fifo_dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  localparam int GRD_W = (RD_GUARD > 0) ? $clog2(RD_GUARD + 1) : 1;

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  rr_ptr, rr_ptr_nxt, grant;
  logic [GRD_W-1:0]  guard;
  logic [NUM_WR-1:0] ack_q, ack_nxt;
  logic [WIDTH-1:0]  wr_word [NUM_WR];
  logic              any_wr, do_rd, do_wr;

  for (genvar g = 0; g < NUM_WR; g++) begin : g_unpack
    assign wr_word[g] = wr_data[g*WIDTH +: WIDTH];
  end

  // Cyclic search for the first requester at or after rr_ptr
  always_comb begin
    int j;
    logic [PTR_W-1:0] idx;
    grant      = '0;
    any_wr     = 1'b0;
    rr_ptr_nxt = rr_ptr;
    for (int k = 0; k < NUM_WR; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_WR) j = j - NUM_WR;
      idx = PTR_W'(j);
      if (!any_wr && wr_req[idx]) begin
        grant  = idx;
        any_wr = 1'b1;
      end
    end
    j = int'(grant) + 1;
    if (j >= NUM_WR) j = 0;
    rr_ptr_nxt = PTR_W'(j);
  end

  assign do_rd = (state == IDLE) && rd_req && !empty && (guard == '0);
  assign do_wr = (state == IDLE) && !do_rd && any_wr && !full;

  always_comb begin
    state_nxt = IDLE;
    ack_nxt   = '0;
    if (do_rd) begin
      state_nxt = RD;
    end else if (do_wr) begin
      state_nxt      = WR;
      ack_nxt[grant] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ack_q    <= '0;
      count    <= '0;
      rr_ptr   <= '0;
      guard    <= '0;
      rd_data  <= '0;
      fifo_din <= '0;
    end else begin
      state <= state_nxt;
      ack_q <= ack_nxt;
      if (do_rd || do_wr) guard <= GRD_W'(RD_GUARD);
      else if (guard != '0) guard <= guard - GRD_W'(1);
      if (do_rd) begin
        rd_data <= fifo_dout;
        count   <= count - CNT_W'(1);
      end
      if (do_wr) begin
        fifo_din <= wr_word[grant];
        rr_ptr   <= rr_ptr_nxt;
        count    <= count + CNT_W'(1);
      end
    end
  end

  // A reset landing in the strobe cycle suppresses the handshake for that access
  assign fifo_wr  = (state == WR);
  assign fifo_rd  = (state == RD);
  assign wr_ack   = rst ? '0 : ack_q;
  assign rd_valid = fifo_rd && !rst;
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: tb/tb_fifo_access_scheduler.sv
// Bench for fifo_access_scheduler: table-driven arbitration vectors, scoreboarded
// reads, and hand sequences for full, guard, contention and reset corners.
module tb_fifo_access_scheduler;

  localparam int WIDTH    = 16;
  localparam int DEPTH    = 512;
  localparam int NUM_WR   = 4;
  localparam int RD_GUARD = 3;
  localparam int CNT_W    = $clog2(DEPTH + 1);

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_WR-1:0]       wr_req;
  logic [NUM_WR*WIDTH-1:0] wr_data;
  logic [NUM_WR-1:0]       wr_ack;
  logic                    rd_req;
  logic                    rd_valid;
  logic [WIDTH-1:0]        rd_data;
  logic                    fifo_wr;
  logic [WIDTH-1:0]        fifo_din;
  logic                    fifo_rd;
  logic [WIDTH-1:0]        fifo_dout;
  logic [CNT_W-1:0]        count;
  logic                    full;
  logic                    empty;

  fifo_access_scheduler #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_WR(NUM_WR), .RD_GUARD(RD_GUARD)
  ) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
    .fifo_wr(fifo_wr), .fifo_din(fifo_din), .fifo_rd(fifo_rd), .fifo_dout(fifo_dout),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // FIFO model: head word reaches fifo_dout three cycles after the edge that changes it
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] d1, d2;
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
    end else begin
      if (fifo_wr) begin
        checks++;
        if (mq.size() >= DEPTH) begin
          errors++;
          $display("FAIL fifo_overflow: size %0d limit %0d", mq.size(), DEPTH);
        end else mq.push_back(fifo_din);
      end
      if (fifo_rd) begin
        checks++;
        if (mq.size() == 0) begin
          errors++;
          $display("FAIL fifo_underflow: size 0 required nonzero");
        end else void'(mq.pop_front());
      end
    end
    d1        <= (mq.size() > 0) ? mq[0] : '0;
    d2        <= d1;
    fifo_dout <= d2;
  end

  typedef struct {
    logic [NUM_WR-1:0] req;
    logic [NUM_WR-1:0] ack;
    logic [WIDTH-1:0]  din;
  } vec_t;

  typedef struct {
    int               idx;
    logic [WIDTH-1:0] data;
  } gnt_t;

  vec_t             tbl[9];
  logic [WIDTH-1:0] rd_exp[$];
  gnt_t             gnt_exp[$];

  task automatic do_reset();
    rst    = 1'b1;
    wr_req = '0;
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_write(input int p, input logic [WIDTH-1:0] v);
    logic [NUM_WR-1:0] got;
    got = '0;
    wr_data[p*WIDTH +: WIDTH] = v;
    wr_req = NUM_WR'(1) << p;
    for (int c = 0; c < 10 && got == '0; c++) begin
      @(negedge clk);
      got = wr_ack;
    end
    chk("push_ack", got, NUM_WR'(1) << p);
    wr_req = '0;
  endtask

  task automatic drain(input string tag, input int budget);
    int last, n, extra;
    logic [WIDTH-1:0] e;
    last = 0; n = 0; extra = 0; e = '0;
    rd_req = 1'b1;
    for (int c = 0; c < budget && rd_exp.size() > 0; c++) begin
      @(negedge clk);
      if (rd_valid) begin
        e = rd_exp.pop_front();
        chk({tag, "_data"}, rd_data, e);
        if (n > 0) chk({tag, "_gap"}, 32'((cyc - last) >= RD_GUARD + 1), 1);
        last = cyc;
        n++;
      end
    end
    chk({tag, "_left"}, rd_exp.size(), 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (fifo_rd) extra++;
    end
    chk({tag, "_extra_rd"}, extra, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_hold"}, rd_data, e);
    rd_req = 1'b0;
  endtask

  initial begin
    logic [NUM_WR-1:0] got;
    logic [WIDTH-1:0]  din_seen;
    gnt_t g;
    int last_ack, blocked;
    logic prev_wr, seen;

    tbl[0] = '{4'b0100, 4'b0100, 16'h3333};
    tbl[1] = '{4'b0011, 4'b0001, 16'h1111};
    tbl[2] = '{4'b1001, 4'b1000, 16'h4444};
    tbl[3] = '{4'b1111, 4'b0001, 16'h1111};
    tbl[4] = '{4'b0000, 4'b0000, 16'h0000};
    tbl[5] = '{4'b0001, 4'b0001, 16'h1111};
    tbl[6] = '{4'b1110, 4'b0010, 16'h2222};
    tbl[7] = '{4'b0010, 4'b0010, 16'h2222};
    tbl[8] = '{4'b1000, 4'b1000, 16'h4444};

    wr_data = '0;
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_fifo_wr", fifo_wr, 0);
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_rd_data", rd_data, 0);

    // Single producer, request held for two strobes
    do_reset();
    wr_data[0 +: WIDTH] = 16'h1234;
    wr_req = 4'b0001;
    @(negedge clk);
    chk("sp_wr1", fifo_wr, 1);
    chk("sp_ack1", wr_ack, 4'b0001);
    chk("sp_din1", fifo_din, 16'h1234);
    chk("sp_cnt1", count, 1);
    @(negedge clk);
    chk("sp_gap_wr", fifo_wr, 0);
    chk("sp_gap_ack", wr_ack, 0);
    @(negedge clk);
    chk("sp_wr2", fifo_wr, 1);
    chk("sp_cnt2", count, 2);
    wr_req = '0;
    @(negedge clk);
    chk("sp_idle_wr", fifo_wr, 0);
    chk("sp_cnt_end", count, 2);

    // Round-robin with all producers held
    do_reset();
    for (int i = 0; i < NUM_WR; i++) wr_data[i*WIDTH +: WIDTH] = 16'hA000 + 16'(i);
    gnt_exp.push_back('{0, 16'hA000});
    gnt_exp.push_back('{1, 16'hA001});
    gnt_exp.push_back('{2, 16'hA002});
    gnt_exp.push_back('{3, 16'hA003});
    gnt_exp.push_back('{0, 16'hA000});
    wr_req   = 4'b1111;
    prev_wr  = 1'b0;
    seen     = 1'b0;
    last_ack = 0;
    for (int c = 0; c < 20 && gnt_exp.size() > 0; c++) begin
      @(negedge clk);
      if (fifo_wr) chk("rr_b2b", prev_wr, 0);
      if (wr_ack != '0) begin
        g = gnt_exp.pop_front();
        chk("rr_ack", wr_ack, NUM_WR'(1) << g.idx);
        chk("rr_din", fifo_din, g.data);
        if (seen) chk("rr_spacing", cyc - last_ack, 2);
        last_ack = cyc;
        seen = 1'b1;
      end
      prev_wr = fifo_wr;
    end
    wr_req = '0;
    chk("rr_left", gnt_exp.size(), 0);

    // Table of arbitration vectors; accepted words are then drained through the read path
    do_reset();
    for (int i = 0; i < NUM_WR; i++) wr_data[i*WIDTH +: WIDTH] = 16'h1111 * 16'(i + 1);
    for (int r = 0; r < 9; r++) begin
      wr_req = tbl[r].req;
      if (tbl[r].ack != '0) rd_exp.push_back(tbl[r].din);
      got = '0;
      din_seen = '0;
      for (int c = 0; c < 6 && got == '0; c++) begin
        @(negedge clk);
        got = wr_ack;
        din_seen = fifo_din;
      end
      chk($sformatf("tbl%0d_ack", r), got, tbl[r].ack);
      if (tbl[r].ack != '0) chk($sformatf("tbl%0d_din", r), din_seen, tbl[r].din);
      wr_req = '0;
    end
    @(negedge clk);
    chk("tbl_count", count, 8);
    drain("tbl_rd", 80);
    chk("tbl_count_end", count, 0);

    // Read path
    do_reset();
    push_write(1, 16'hAAAA);
    rd_exp.push_back(16'hAAAA);
    push_write(1, 16'hBBBB);
    rd_exp.push_back(16'hBBBB);
    drain("rdp", 40);

    // Fill to DEPTH, confirm writes stall, then one read releases the pending write
    do_reset();
    wr_data[0 +: WIDTH] = 16'h0F0F;
    wr_req = 4'b0001;
    for (int c = 0; c < 1200 && !full; c++) @(negedge clk);
    chk("full_count", count, DEPTH);
    chk("full_flag", full, 1);
    chk("full_empty", empty, 0);
    blocked = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (fifo_wr || wr_ack != '0) blocked++;
    end
    chk("full_blocked", blocked, 0);
    rd_req = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = rd_valid;
    end
    rd_req = 1'b0;
    chk("full_rd_seen", seen, 1);
    chk("full_rd_data", rd_data, 16'h0F0F);
    chk("full_clear", full, 0);
    got = '0;
    for (int c = 0; c < 10 && got == '0; c++) begin
      @(negedge clk);
      got = wr_ack;
    end
    chk("full_resume_ack", got, 4'b0001);
    chk("full_resume_cnt", count, DEPTH);
    wr_req = '0;

    // Contention: read wins over write, then reset lands in the write strobe cycle
    do_reset();
    for (int k = 0; k < 5; k++) push_write(3, 16'h5000 + 16'(k));
    repeat (5) @(negedge clk);
    chk("ct_count5", count, 5);
    wr_data[2*WIDTH +: WIDTH] = 16'h7777;
    rd_req = 1'b1;
    wr_req = 4'b0100;
    @(negedge clk);
    chk("ct_rd_first", rd_valid, 1);
    chk("ct_rd_data", rd_data, 16'h5000);
    chk("ct_no_ack", wr_ack, 0);
    chk("ct_count4", count, 4);
    rd_req = 1'b0;
    @(negedge clk);
    chk("ct_idle_wr", fifo_wr, 0);
    chk("ct_idle_rd", fifo_rd, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("ct_wr_cycle", fifo_wr, 1);
    chk("ct_rst_no_ack", wr_ack, 0);
    wr_req = '0;
    @(negedge clk);
    chk("ct_rst_count", count, 0);
    chk("ct_rst_empty", empty, 1);
    chk("ct_rst_fifo_wr", fifo_wr, 0);
    chk("ct_rst_ack2", wr_ack, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_access_scheduler.md
Name: fifo_access_scheduler

Overview:
- Arbitrates between NUM_WR sample producers (track recorders, loop capture) and one playback consumer that share a single edge-strobed BRAM sample FIFO.
- Generates the FIFO's rd/wr strobes as single-cycle pulses, each separated by at least one low cycle.
- Tracks FIFO occupancy, blocks writes when full and reads when empty.
- Hides the FIFO's read-path latency behind a valid pulse.

Parameters:
- WIDTH, 16, sample word width.
- DEPTH, 512, FIFO entries; must match the attached FIFO.
- NUM_WR, 4, number of producer ports (1..8).
- RD_GUARD, 3, cycles after any strobe before fifo_dout is trusted as the head word.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset; the same rst also drives the FIFO.
- wr_req  in  NUM_WR  per-producer request level; held until wr_ack.
- wr_data  in  NUM_WR*WIDTH  producer i data at bits [i*WIDTH +: WIDTH].
- wr_ack  out  NUM_WR  one-hot 1-cycle pulse; the request is accepted this cycle.
- rd_req  in  1  consumer request level.
- rd_valid  out  1  1-cycle pulse; rd_data holds a popped sample.
- rd_data  out  WIDTH  popped sample; holds its value until the next pop.
- fifo_wr  out  1  write strobe to the FIFO.
- fifo_din  out  WIDTH  write data to the FIFO.
- fifo_rd  out  1  read/advance strobe to the FIFO.
- fifo_dout  in  WIDTH  FIFO head word.
- count  out  clog2(DEPTH+1)  occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset values:
  - state = IDLE.
  - All strobes, wr_ack, rd_valid = 0.
  - rd_data = 0, fifo_din = 0, count = 0.
  - rr_ptr = 0, guard = 0.
  - empty = 1, full = 0.
- Reset mid-operation: next cycle is IDLE with all strobes low. No ack or valid is emitted for the interrupted operation. count is cleared; this matches the FIFO, which is reset by the same rst.
- FSM states: IDLE, WR, RD. Every operation is exactly 2 cycles: an IDLE decision cycle followed by a WR or RD cycle. Return to IDLE is unconditional.
- Outputs registered from state:
  - fifo_wr = (state == WR); wr_ack is active in that cycle.
  - fifo_rd = (state == RD); rd_valid is active in that cycle.
  - IDLE is therefore always a low cycle between strobes, which the FIFO's edge detect requires.
- IDLE decision, in priority order:
  1. rd_req && !empty && guard == 0 -> RD. Capture rd_data <= fifo_dout on the transition edge. Decrement count.
  2. Else if any wr_req && !full -> WR. Grant the lowest index i at or after rr_ptr (cyclic). Set fifo_din <= wr_data[i], set rr_ptr <= (i+1) mod NUM_WR, increment count.
  3. Else stay in IDLE.
- Requests are sampled only in IDLE. A wr_req dropped before its ack has no effect.
- Read priority avoids playback underrun. Writers cannot starve, because guard forces idle windows between reads in which writes may issue.
- Guard timing:
  - guard is loaded with RD_GUARD on entry to WR or RD, and decrements by 1 per cycle while nonzero.
  - A strobe high in cycle T allows the earliest read capture at the end of cycle T+RD_GUARD.
  - Writes are never gated by guard.
- Occupancy: count increments or decrements by exactly 1 per operation, and never both in the same operation. Overflow is impossible: no write is issued when full. Underflow is impossible: no read is issued when empty.
- Wrap-around is handled inside the FIFO. The scheduler only needs count to distinguish full (DEPTH) from empty (0).
- Throughput:
  - Maximum one write per 2 cycles.
  - Maximum one read per max(2, RD_GUARD+1) cycles.

Test Plan:
- Reset: assert rst 2 cycles -> count=0, empty=1, full=0, fifo_wr=fifo_rd=0, rd_valid=0.
- Single producer: wr_req[0]=1, data 0x1234 from empty -> fifo_wr pulse of 1 cycle with fifo_din=0x1234, wr_ack[0] in the same cycle, count=1; held req yields a strobe every 2nd cycle.
- Round-robin fairness: all 4 wr_req held -> grant order 0,1,2,3,0; each ack 2 cycles apart; no back-to-back fifo_wr highs.
- Full: write 512 words with rd_req=0 -> full=1; further wr_req gets no ack and no fifo_wr; one read -> full=0 and the pending write proceeds.
- Read path: preload 0xAAAA, 0xBBBB through the FIFO model; hold rd_req -> rd_valid with 0xAAAA, then 0xBBBB, at least RD_GUARD+1 cycles apart; empty=1 afterwards and no further fifo_rd.
- Contention and reset: rd_req plus wr_req[2] together with count=5 and guard=0 -> RD first, WR next; assert rst during the WR cycle -> no ack, count=0 on the next cycle.
